// File: rtl/amo_pkg.sv
// amo_pkg: shared constants for the AMO read-modify-write sequencer.
//   - M_XA_* : AMO command encodings accepted on req_cmd
//   - S_*    : sequencer FSM state encodings
//   - cmd_legal / mask_legal : request legality helpers used in CHECK
package amo_pkg;

    localparam logic [4:0] M_XA_SWAP = 5'h04;
    localparam logic [4:0] M_XA_ADD  = 5'h08;
    localparam logic [4:0] M_XA_XOR  = 5'h09;
    localparam logic [4:0] M_XA_OR   = 5'h0A;
    localparam logic [4:0] M_XA_AND  = 5'h0B;
    localparam logic [4:0] M_XA_MIN  = 5'h0C;
    localparam logic [4:0] M_XA_MAX  = 5'h0D;
    localparam logic [4:0] M_XA_MINU = 5'h0E;
    localparam logic [4:0] M_XA_MAXU = 5'h0F;

    // Legal byte masks: low word, high word, full doubleword
    localparam logic [7:0] MASK_LO   = 8'h0F;
    localparam logic [7:0] MASK_HI   = 8'hF0;
    localparam logic [7:0] MASK_FULL = 8'hFF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_WR_REQ  = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    // SWAP plus the contiguous 0x8..0xF arithmetic/logic/compare block
    function automatic logic cmd_legal(input logic [4:0] cmd);
        return (cmd == M_XA_SWAP) || (cmd[4:3] == 2'b01);
    endfunction

    function automatic logic mask_legal(input logic [7:0] mask);
        return (mask == MASK_LO) || (mask == MASK_HI) || (mask == MASK_FULL);
    endfunction

endpackage

// File: rtl/amo_rmw_sequencer_alu.sv
// amo_rmw_sequencer_alu: combinational AMO datapath (AMOALU).
//   io_mask : byte mask (0x0F low word, 0xF0 high word, 0xFF doubleword)
//   io_cmd  : M_XA_* command
//   io_lhs  : old memory doubleword
//   io_rhs  : request operand, word-aligned to the same half as io_mask
//   io_out  : merged result; bytes outside io_mask keep io_lhs
module amo_rmw_sequencer_alu
    import amo_pkg::*;
(
    input  logic [7:0]  io_mask,
    input  logic [4:0]  io_cmd,
    input  logic [63:0] io_lhs,
    input  logic [63:0] io_rhs,
    output logic [63:0] io_out
);

    logic [63:0] bmask;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] a_cmp;
    logic [63:0] b_cmp;
    logic [63:0] res;
    logic        signed_op;
    logic        lt;

    always_comb begin
        bmask = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            bmask[i*8 +: 8] = {8{io_mask[i]}};
        end

        // Zeroing the inactive word isolates the add carry and lets the
        // high-word case compare as a plain 64-bit value.
        a = io_lhs & bmask;
        b = io_rhs & bmask;

        signed_op = (io_cmd == M_XA_MIN) || (io_cmd == M_XA_MAX);

        // Low-word compares need the word's sign bit extended upward.
        if (io_mask == MASK_LO) begin
            a_cmp = {{32{signed_op & a[31]}}, a[31:0]};
            b_cmp = {{32{signed_op & b[31]}}, b[31:0]};
        end else begin
            a_cmp = a;
            b_cmp = b;
        end

        lt = signed_op ? ($signed(a_cmp) < $signed(b_cmp)) : (a_cmp < b_cmp);

        case (io_cmd)
            M_XA_SWAP: res = b;
            M_XA_ADD:  res = a + b;
            M_XA_XOR:  res = a ^ b;
            M_XA_OR:   res = a | b;
            M_XA_AND:  res = a & b;
            M_XA_MIN:  res = lt ? a : b;
            M_XA_MAX:  res = lt ? b : a;
            M_XA_MINU: res = lt ? a : b;
            M_XA_MAXU: res = lt ? b : a;
            default:   res = b;
        endcase

        io_out = (res & bmask) | (io_lhs & ~bmask);
    end

endmodule

// File: rtl/amo_rmw_sequencer.sv
// amo_rmw_sequencer: performs one atomic read-modify-write at a time.
//   clock/reset          : single rising-edge clock, async active-high reset
//   req_*                : AMO request (valid/ready, addr, cmd, mask, data, tag)
//   mem_rd_* / mem_rdata*: read request handshake and single-beat data return
//   mem_wr_*             : write request handshake with merged data and mask
//   resp_*               : response (old value, echoed tag, error flag)
//   busy                 : high whenever a request is in progress
module amo_rmw_sequencer
    import amo_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int TAG_W    = 4,
    parameter int MAX_WAIT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [4:0]        req_cmd,
    input  logic [7:0]        req_mask,
    input  logic [63:0]       req_data,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              mem_rd_valid,
    input  logic              mem_rd_ready,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rdata_valid,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_rerr,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [63:0]       mem_wr_data,
    output logic [7:0]        mem_wr_mask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_err,
    output logic              busy
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        cmd_q;
    logic [7:0]        mask_q;
    logic [63:0]       data_q;
    logic [TAG_W-1:0]  tag_q;
    logic [63:0]       old_q;
    logic [63:0]       wr_data_q;
    logic              err_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [63:0]       alu_out;

    amo_rmw_sequencer_alu u_alu (
        .io_mask (mask_q),
        .io_cmd  (cmd_q),
        .io_lhs  (mem_rdata),
        .io_rhs  (data_q),
        .io_out  (alu_out)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            cmd_q     <= '0;
            mask_q    <= '0;
            data_q    <= '0;
            tag_q     <= '0;
            old_q     <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        cmd_q     <= req_cmd;
                        mask_q    <= req_mask;
                        data_q    <= req_data;
                        tag_q     <= req_tag;
                        old_q     <= '0;
                        wr_data_q <= '0;
                        err_q     <= 1'b0;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!cmd_legal(cmd_q) || !mask_legal(mask_q) || (addr_q[2:0] != 3'd0)) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (mem_rd_ready) begin
                        wait_cnt <= '0;
                        state    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // Data returning on the final allowed cycle beats the timeout.
                    if (mem_rdata_valid) begin
                        if (mem_rerr) begin
                            err_q <= 1'b1;
                            state <= S_RESP;
                        end else begin
                            old_q     <= mem_rdata;
                            wr_data_q <= alu_out;
                            state     <= S_WR_REQ;
                        end
                    end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WR_REQ: begin
                    if (mem_wr_ready) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready    = (state == S_IDLE);
        busy         = (state != S_IDLE);
        mem_rd_valid = (state == S_RD_REQ);
        mem_rd_addr  = addr_q;
        mem_wr_valid = (state == S_WR_REQ);
        mem_wr_addr  = addr_q;
        mem_wr_data  = wr_data_q;
        mem_wr_mask  = mask_q;
        resp_valid   = (state == S_RESP);
        resp_data    = old_q;
        resp_tag     = tag_q;
        resp_err     = (state == S_RESP) && err_q;
    end

endmodule

// File: tb/tb_amo_rmw_sequencer.sv
module tb_amo_rmw_sequencer;

    localparam int MAXW = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [4:0]  req_cmd;
    logic [7:0]  req_mask;
    logic [63:0] req_data;
    logic [3:0]  req_tag;
    logic        mem_rd_valid;
    logic        mem_rd_ready;
    logic [31:0] mem_rd_addr;
    logic        mem_rdata_valid;
    logic [63:0] mem_rdata;
    logic        mem_rerr;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [7:0]  mem_wr_mask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [3:0]  resp_tag;
    logic        resp_err;
    logic        busy;

    always #5 clock = ~clock;

    amo_rmw_sequencer #(.ADDR_W(32), .TAG_W(4), .MAX_WAIT(MAXW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_cmd(req_cmd), .req_mask(req_mask), .req_data(req_data), .req_tag(req_tag),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .mem_rerr(mem_rerr),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  cmd;
        logic [7:0]  mask;
        logic [63:0] data;
        logic [63:0] mem;
        logic [3:0]  tag;
        int          rd_delay;
        bit          rerr;
        int          stall;
        bit          exp_err;
        logic [63:0] exp_resp;
        logic [63:0] exp_wr;
        int          exp_rd;
        int          exp_lat;
    } vec_t;

    logic [63:0] mem_model [16];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [4:0] cmd, input logic [7:0] mask,
                                input logic [63:0] data, input logic [63:0] mem, input int rd_delay,
                                input bit rerr, input int stall, input bit exp_err,
                                input logic [63:0] exp_resp, input logic [63:0] exp_wr,
                                input int exp_rd, input int exp_lat);
        vec_t v;
        v.addr = addr; v.cmd = cmd; v.mask = mask; v.data = data; v.mem = mem; v.tag = 4'h0;
        v.rd_delay = rd_delay; v.rerr = rerr; v.stall = stall; v.exp_err = exp_err;
        v.exp_resp = exp_resp; v.exp_wr = exp_wr; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Reference AMO: pick the operand field by mask, do the arithmetic on
    // that field, then splice it back into the old doubleword.
    function automatic logic [63:0] ref_amo(input logic [4:0] cmd, input logic [7:0] mask,
                                            input logic [63:0] lhs, input logic [63:0] rhs);
        longint          sa, sb;
        longint unsigned ua, ub, r;
        bit              word;
        bit              hi;
        word = (mask != 8'hFF);
        hi   = (mask == 8'hF0);
        ua   = word ? (hi ? {32'h0, lhs[63:32]} : {32'h0, lhs[31:0]}) : lhs;
        ub   = word ? (hi ? {32'h0, rhs[63:32]} : {32'h0, rhs[31:0]}) : rhs;
        sa   = word ? longint'($signed(ua[31:0])) : longint'(ua);
        sb   = word ? longint'($signed(ub[31:0])) : longint'(ub);
        case (cmd)
            5'h04:   r = ub;
            5'h08:   r = ua + ub;
            5'h09:   r = ua ^ ub;
            5'h0A:   r = ua | ub;
            5'h0B:   r = ua & ub;
            5'h0C:   r = (sa < sb) ? ua : ub;
            5'h0D:   r = (sa > sb) ? ua : ub;
            5'h0E:   r = (ua < ub) ? ua : ub;
            default: r = (ua > ub) ? ua : ub;
        endcase
        if (!word) return r;
        if (hi) return {r[31:0], lhs[31:0]};
        return {lhs[63:32], r[31:0]};
    endfunction

    task automatic run_txn(input int id, input vec_t v);
        int edges, rd_seen, wr_seen, rs_seen, cd, n_rd, n_wr, lat;
        bit done, unstable;
        logic [31:0] rd_a, wr_a;
        logic [63:0] wr_d, r_d;
        logic [7:0]  wr_m;
        logic [3:0]  r_t, idx;
        logic        r_e;
        string       p;
        p = $sformatf("t%0d", id);
        edges = 0; rd_seen = 0; wr_seen = 0; rs_seen = 0; cd = 0; n_rd = 0; n_wr = 0; lat = 0;
        done = 0; unstable = 0;
        rd_a = '0; wr_a = '0; wr_d = '0; r_d = '0; wr_m = '0; r_t = '0; r_e = 1'b0;
        idx = v.addr[6:3];
        mem_model[idx] = v.mem;

        @(negedge clock);
        req_valid = 1'b1; req_addr = v.addr; req_cmd = v.cmd; req_mask = v.mask;
        req_data = v.data; req_tag = v.tag;
        while (!req_ready && edges < 20) begin
            @(negedge clock);
            edges++;
        end
        chk({p, "_req_ready"}, req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        req_data  = {$urandom, $urandom};
        edges = 1;

        while (!done && edges < 300) begin
            mem_rdata_valid = 1'b0;
            mem_rerr        = 1'b0;
            mem_rdata       = {$urandom, $urandom};
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_rdata_valid = 1'b1;
                    mem_rerr        = v.rerr;
                    if (!v.rerr) mem_rdata = mem_model[idx];
                end
            end
            mem_rd_ready = 1'b0;
            if (mem_rd_valid) begin
                if (rd_seen == 0) rd_a = mem_rd_addr;
                else if (mem_rd_addr !== rd_a) unstable = 1;
                rd_seen++;
                if (rd_seen > v.stall) begin
                    mem_rd_ready = 1'b1; n_rd++; cd = v.rd_delay; rd_seen = 0;
                end
            end
            mem_wr_ready = 1'b0;
            if (mem_wr_valid) begin
                if (wr_seen == 0) begin
                    wr_a = mem_wr_addr; wr_d = mem_wr_data; wr_m = mem_wr_mask;
                end else if (mem_wr_addr !== wr_a || mem_wr_data !== wr_d || mem_wr_mask !== wr_m) begin
                    unstable = 1;
                end
                wr_seen++;
                if (wr_seen > v.stall) begin
                    mem_wr_ready = 1'b1; n_wr++; wr_seen = 0;
                end
            end
            resp_ready = 1'b0;
            if (resp_valid) begin
                if (lat == 0) lat = edges;
                if (rs_seen == 0) begin
                    r_d = resp_data; r_e = resp_err; r_t = resp_tag;
                end else if (resp_data !== r_d || resp_err !== r_e || resp_tag !== r_t) begin
                    unstable = 1;
                end
                rs_seen++;
                if (rs_seen > v.stall) begin
                    resp_ready = 1'b1; done = 1;
                end
            end
            @(negedge clock);
            edges++;
        end
        mem_rd_ready = 1'b0; mem_wr_ready = 1'b0; resp_ready = 1'b0;
        mem_rdata_valid = 1'b0; mem_rerr = 1'b0;

        chk({p, "_resp_handshake"}, done, 1);
        chk({p, "_resp_err"}, r_e, v.exp_err);
        chk({p, "_resp_data"}, r_d, v.exp_resp);
        chk({p, "_resp_tag"}, r_t, v.tag);
        chk({p, "_rd_count"}, n_rd, v.exp_rd);
        chk({p, "_wr_count"}, n_wr, v.exp_err ? 0 : 1);
        chk({p, "_stable"}, unstable, 0);
        chk({p, "_idle_after"}, {busy, resp_valid}, 2'b00);
        if (v.exp_rd != 0) chk({p, "_rd_addr"}, rd_a, v.addr);
        if (!v.exp_err) begin
            chk({p, "_wr_data"}, wr_d, v.exp_wr);
            chk({p, "_wr_mask"}, wr_m, v.mask);
            chk({p, "_wr_addr"}, wr_a, v.addr);
            mem_model[idx] = v.exp_wr;
        end
        if (v.exp_lat != 0) chk({p, "_latency"}, lat, v.exp_lat);
    endtask

    vec_t vt[$];
    vec_t v;
    logic [4:0] legal_cmds [9] = '{5'h04, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F};
    logic [4:0] bad_cmds [5]   = '{5'h00, 5'h05, 5'h07, 5'h10, 5'h1F};
    logic [7:0] legal_masks [3] = '{8'h0F, 8'hF0, 8'hFF};
    logic [7:0] bad_masks [4]   = '{8'h00, 8'h03, 8'hFE, 8'hF1};

    initial begin
        int   edges;
        bit   legal;
        logic [3:0] idx;

        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_cmd = '0; req_mask = '0; req_data = '0; req_tag = '0;
        mem_rd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
        mem_wr_ready = 1'b0; resp_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem_model[i] = {$urandom, $urandom};

        #12;
        chk("reset_busy", busy, 0);
        chk("reset_rd_valid", mem_rd_valid, 0);
        chk("reset_wr_valid", mem_wr_valid, 0);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_err", resp_err, 0);
        chk("reset_resp_data", resp_data, 0);
        chk("reset_wr_data", mem_wr_data, 0);
        chk("reset_req_ready", req_ready, 1);
        @(negedge clock);
        reset = 1'b0;

        vt.push_back(mk(32'h08, 5'h08, 8'hFF, 64'h3, 64'h5, 1, 0, 0, 0, 64'h5, 64'h8, 1, 5));
        vt.push_back(mk(32'h10, 5'h0D, 8'h0F, 64'h1, 64'hAAAA_AAAA_FFFF_FFFF, 1, 0, 0, 0,
                        64'hAAAA_AAAA_FFFF_FFFF, 64'hAAAA_AAAA_0000_0001, 1, 5));
        vt.push_back(mk(32'h18, 5'h05, 8'hFF, 64'h1, 64'h9, 1, 0, 0, 1, 64'h0, 64'h0, 0, 0));
        vt.push_back(mk(32'h20, 5'h08, 8'h03, 64'h1, 64'h9, 1, 0, 0, 1, 64'h0, 64'h0, 0, 0));
        vt.push_back(mk(32'h24, 5'h08, 8'hFF, 64'h1, 64'h9, 1, 0, 0, 1, 64'h0, 64'h0, 0, 0));
        vt.push_back(mk(32'h28, 5'h08, 8'hFF, 64'h1, 64'h77, 1, 1, 0, 1, 64'h0, 64'h0, 1, 0));
        vt.push_back(mk(32'h30, 5'h08, 8'hF0, 64'h0000_0002_0000_0005, 64'h0000_0001_FFFF_FFFF, MAXW, 0, 0, 0,
                        64'h0000_0001_FFFF_FFFF, 64'h0000_0003_FFFF_FFFF, 1, 0));
        vt.push_back(mk(32'h38, 5'h08, 8'hFF, 64'h1, 64'h9, MAXW + 1, 0, 0, 1, 64'h0, 64'h0, 1, 0));
        vt.push_back(mk(32'h40, 5'h04, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'h1111, 1, 0, 10, 0,
                        64'h1111, 64'hDEAD_BEEF_CAFE_F00D, 1, 0));
        vt.push_back(mk(32'h48, 5'h0E, 8'hF0, 64'h0000_0001_1234_5678, 64'h8000_0000_0000_0000, 1, 0, 0, 0,
                        64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000, 1, 0));
        vt.push_back(mk(32'h50, 5'h08, 8'hFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0,
                        64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1, 0));
        vt.push_back(mk(32'h58, 5'h0C, 8'hFF, 64'h5, 64'h8000_0000_0000_0000, 1, 0, 0, 0,
                        64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 0));
        vt.push_back(mk(32'h60, 5'h09, 8'h0F, 64'hFFFF_FFFF_0000_FFFF, 64'h1234_5678_9ABC_DEF0, 2, 0, 1, 0,
                        64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_210F, 1, 0));
        vt.push_back(mk(32'h70, 5'h0A, 8'hF0, 64'h0F0F_0000_FFFF_FFFF, 64'hF000_0000_1234_5678, 1, 0, 0, 0,
                        64'hF000_0000_1234_5678, 64'hFF0F_0000_1234_5678, 1, 0));
        vt.push_back(mk(32'h78, 5'h0B, 8'h0F, 64'h0000_0000_0000_FF00, 64'hFFFF_FFFF_1234_5678, 1, 0, 0, 0,
                        64'hFFFF_FFFF_1234_5678, 64'hFFFF_FFFF_0000_5600, 1, 0));
        vt.push_back(mk(32'h68, 5'h0F, 8'hFF, 64'h7, 64'h3, 1, 0, 2, 0, 64'h3, 64'h7, 1, 0));

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            v.tag = 4'(i);
            run_txn(i, v);
        end

        // Reset while the write request is stalled: write dropped, no response,
        // stale read data afterwards ignored, next request unaffected.
        mem_model[2] = 64'h100;
        @(negedge clock);
        req_valid = 1'b1; req_addr = 32'h10; req_cmd = 5'h08; req_mask = 8'hFF;
        req_data = 64'h1; req_tag = 4'h7;
        mem_rd_ready = 1'b1; mem_wr_ready = 1'b0; resp_ready = 1'b0;
        mem_rdata_valid = 1'b1; mem_rdata = 64'h100; mem_rerr = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        edges = 0;
        while (!mem_wr_valid && edges < 20) begin
            @(negedge clock);
            edges++;
        end
        chk("rst_reached_wr", mem_wr_valid, 1);
        chk("rst_pre_wr_data", mem_wr_data, 64'h101);
        reset = 1'b1;
        #1;
        chk("rst_wr_valid", mem_wr_valid, 0);
        chk("rst_rd_valid", mem_rd_valid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        chk("rst_resp_tag", resp_tag, 0);
        chk("rst_resp_data", resp_data, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("stale_busy_%0d", k), busy, 0);
            chk($sformatf("stale_wr_valid_%0d", k), mem_wr_valid, 0);
        end
        mem_rdata_valid = 1'b0; mem_rd_ready = 1'b0;
        run_txn(100, mk(32'h10, 5'h08, 8'hFF, 64'h1, 64'h100, 1, 0, 0, 0, 64'h100, 64'h101, 1, 5));

        // Randomized requests against the reference model
        for (int k = 0; k < 150; k++) begin
            idx = 4'($urandom_range(0, 15));
            v.addr = {25'h0, idx, 3'b000};
            if ($urandom_range(0, 11) == 0) v.addr[2:0] = 3'($urandom_range(1, 7));
            v.cmd  = ($urandom_range(0, 9) == 0) ? bad_cmds[$urandom_range(0, 4)] : legal_cmds[$urandom_range(0, 8)];
            v.mask = ($urandom_range(0, 9) == 0) ? bad_masks[$urandom_range(0, 3)] : legal_masks[$urandom_range(0, 2)];
            v.data = {$urandom, $urandom};
            v.mem  = mem_model[idx];
            v.tag  = 4'($urandom);
            v.rd_delay = $urandom_range(1, 4);
            v.rerr = ($urandom_range(0, 9) == 0);
            v.stall = $urandom_range(0, 2);
            legal = (v.cmd inside {5'h04, [5'h08:5'h0F]}) && (v.mask inside {8'h0F, 8'hF0, 8'hFF})
                    && (v.addr[2:0] == 3'b000);
            v.exp_err  = !legal || v.rerr;
            v.exp_rd   = legal ? 1 : 0;
            v.exp_resp = v.exp_err ? 64'h0 : v.mem;
            v.exp_wr   = ref_amo(v.cmd, v.mask, v.mem, v.data);
            v.exp_lat  = 0;
            run_txn(200 + k, v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "testbench time limit");
    end

endmodule
